// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event detector.
//
// Contents:
//   state_e      per-channel debounce FSM state
//   EV_PRESS     event-mode mask bit: press/release edges set pending on press
//   EV_RELEASE   event-mode mask bit: release edges set pending on release
//   ST_WIDTH     width of one encoded state, used to pack debug state vectors
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_e;

    localparam int ST_WIDTH = 2;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;

endpackage

// File: rtl/button_event_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with stability
// counter, long-press (hold) counter and a sticky event-pending bit.
//
// Ports:
//   clk_i      clock
//   reset_ni   asynchronous active-low reset
//   data_i     raw asynchronous button input
//   tick_i     shared prescaler tick, one clk every TIMEOUT clks
//   clear_i    write-1-to-clear for the pending bit
//   level_o    debounced level, 1 = pressed
//   press_o    1-clk pulse on accepted press
//   release_o  1-clk pulse on accepted release
//   hold_o     1-clk pulse when the hold threshold is reached
//   pending_o  sticky event flag
//   state_o    current FSM state (debug visibility)
//
// Handshake: none; all outputs are registered levels or 1-clk pulses.
module button_event_channel
    import button_event_pkg::*;
#(
    parameter logic       PRESSED_LOW   = 1'b1,
    parameter int         TIMEOUT       = 50000,
    parameter int         TIMEOUT_WIDTH = 16,
    parameter int         HOLD_TICKS    = 1000,
    parameter int         HOLD_WIDTH    = 10,
    parameter logic [1:0] EV_MASK       = EV_PRESS | EV_RELEASE
) (
    input  logic   clk_i,
    input  logic   reset_ni,
    input  logic   data_i,
    input  logic   tick_i,
    input  logic   clear_i,
    output logic   level_o,
    output logic   press_o,
    output logic   release_o,
    output logic   hold_o,
    output logic   pending_o,
    output state_e state_o
);

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [HOLD_WIDTH-1:0]    HOLD_MAX = HOLD_WIDTH'(HOLD_TICKS);
    localparam logic                     SET_ON_PRESS   = |(EV_MASK & EV_PRESS);
    localparam logic                     SET_ON_RELEASE = |(EV_MASK & EV_RELEASE);

    // ------------------------------------------------------------------
    // Synchroniser. Resets to the released level so that leaving reset
    // with the button held is seen as a fresh press edge.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       pressed_lvl;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q <= {2{PRESSED_LOW}};
        end else begin
            sync_q <= {sync_q[0], data_i};
        end
    end

    assign pressed_lvl = sync_q[1] ^ PRESSED_LOW;

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     level_q, level_d;
    logic                     press_q, press_d;
    logic                     release_q, release_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The counter starts at 0 on the clk the FSM enters a debounce state
    // and the level is accepted when it reads TIMEOUT-1 with the input
    // still stable. Together with the 2 synchroniser flops this gives a
    // latency of TIMEOUT+2 clks from the first edge seeing the new level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed_lvl) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!pressed_lvl) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (!pressed_lvl) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (pressed_lvl) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == DEB_RELEASE);
    end

    // ------------------------------------------------------------------
    // Hold counter. Cleared on the press itself; counts ticks only on
    // later clks in PRESSED/DEB_RELEASE, so a bounce back to PRESSED keeps
    // its progress. The clk that completes a release is excluded so that
    // hold and release can never pulse together. Saturates at HOLD_MAX,
    // which also makes HOLD_TICKS=0 a permanent disable.
    // ------------------------------------------------------------------
    logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                  hold_q, hold_d;
    logic                  hold_en;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_d     = 1'b0;
        hold_en    = ((state_q == PRESSED) || (state_q == DEB_RELEASE)) && !release_d;
        if (press_d) begin
            hold_cnt_d = '0;
        end else if ((HOLD_TICKS > 0) && hold_en && tick_i && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HOLD_WIDTH'(1);
            hold_d     = (hold_cnt_d == HOLD_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Sticky pending bit, set from the registered pulses. A set in the
    // same clk as a clear wins.
    // ------------------------------------------------------------------
    logic pending_q, pending_d;
    logic pending_set;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        pending_set = (press_q & SET_ON_PRESS) | (release_q & SET_ON_RELEASE) | hold_q;
        pending_d   = pending_set | (pending_q & ~clear_i);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hold_q;
    assign pending_o = pending_q;
    assign state_o   = state_q;

endmodule

// File: rtl/button_event_detector.sv
// Multi-channel push-button event detector. Each channel is synchronised
// and debounced independently and reports press, release and long-press
// pulses; events latch into sticky pending bits that drive one level IRQ.
//
// Ports:
//   clk            single clock
//   reset_n        asynchronous active-low reset
//   data_in        raw button inputs
//   data_out       debounced levels, 1 = pressed
//   press_pulse    1-clk pulse per accepted press
//   release_pulse  1-clk pulse per accepted release
//   hold_pulse     1-clk pulse once per press at the hold threshold
//   event_pending  sticky per-channel event flags
//   event_clear    write-1-to-clear for event_pending, sampled every clk
//   irq            registered OR of event_pending
//   debug_state    packed FSM states, channel g at [2g+1:2g]
module button_event_detector
    import button_event_pkg::*;
#(
    parameter int    WIDTH         = 2,
    parameter string POLARITY      = "LOW",
    parameter int    TIMEOUT       = 50000,
    parameter int    TIMEOUT_WIDTH = 16,
    parameter int    HOLD_TICKS    = 1000,
    parameter int    HOLD_WIDTH    = 10,
    parameter string EVENT_MODE    = "BOTH"
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic [WIDTH-1:0]          press_pulse,
    output logic [WIDTH-1:0]          release_pulse,
    output logic [WIDTH-1:0]          hold_pulse,
    output logic [WIDTH-1:0]          event_pending,
    input  logic [WIDTH-1:0]          event_clear,
    output logic                      irq,
    output logic [ST_WIDTH*WIDTH-1:0] debug_state
);

    localparam logic PRESSED_LOW = (POLARITY == "LOW") ? 1'b1 : 1'b0;

    localparam logic [1:0] EV_MASK =
        (EVENT_MODE == "PRESS")   ? EV_PRESS   :
        (EVENT_MODE == "RELEASE") ? EV_RELEASE :
                                    (EV_PRESS | EV_RELEASE);

    localparam logic [TIMEOUT_WIDTH-1:0] PRESC_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Free-running tick prescaler shared by all hold counters. The tick is
    // combinational so every channel sees it on the same clk.
    // ------------------------------------------------------------------
    logic [TIMEOUT_WIDTH-1:0] presc_q, presc_d;
    logic                     tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + TIMEOUT_WIDTH'(1);
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_e ch_state;

        button_event_channel #(
            .PRESSED_LOW   (PRESSED_LOW),
            .TIMEOUT       (TIMEOUT),
            .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
            .HOLD_TICKS    (HOLD_TICKS),
            .HOLD_WIDTH    (HOLD_WIDTH),
            .EV_MASK       (EV_MASK)
        ) u_channel (
            .clk_i     (clk),
            .reset_ni  (reset_n),
            .data_i    (data_in[g]),
            .tick_i    (tick),
            .clear_i   (event_clear[g]),
            .level_o   (data_out[g]),
            .press_o   (press_pulse[g]),
            .release_o (release_pulse[g]),
            .hold_o    (hold_pulse[g]),
            .pending_o (event_pending[g]),
            .state_o   (ch_state)
        );

        assign debug_state[ST_WIDTH*g +: ST_WIDTH] = ch_state;
    end

    // ------------------------------------------------------------------
    // IRQ: registered OR, lags pending by one clk.
    // ------------------------------------------------------------------
    logic irq_q, irq_d;

    always_comb begin
        irq_d = |event_pending;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector with a press/release event
// scoreboard and direct level checks.
module tb_button_event_detector;
  import button_event_pkg::*;

  localparam int WIDTH = 2;
  localparam int EW    = 19;  // {kind[1:0], ch, cyc[15:0]}
  localparam logic [1:0] K_PRESS   = 2'd1;
  localparam logic [1:0] K_RELEASE = 2'd2;
  localparam int LAT = 7;     // drive at negedge n -> pulse seen at negedge n+7

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0]   data_in = '1;
  logic [WIDTH-1:0]   event_clear = '0;
  logic [WIDTH-1:0]   data_out, press_pulse, release_pulse, hold_pulse, event_pending;
  logic               irq;
  logic [2*WIDTH-1:0] debug_state;

  button_event_detector #(
    .WIDTH(WIDTH), .POLARITY("LOW"), .TIMEOUT(4), .TIMEOUT_WIDTH(3),
    .HOLD_TICKS(3), .HOLD_WIDTH(2), .EVENT_MODE("BOTH")
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .hold_pulse(hold_pulse),
    .event_pending(event_pending), .event_clear(event_clear), .irq(irq),
    .debug_state(debug_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int hold_cnt[WIDTH];
  int hold_cyc[WIDTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ev_seen(input logic [1:0] kind, input int ch);
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    obs = {kind, 1'(ch), 16'(cyc)};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL unexpected_event observed=%h expected=none", obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_errors++;
        $error("FAIL event observed=%h expected=%h", obs, exp);
      end
    end
  endtask

  // monitor: press/release through the queue, hold pulses recorded
  initial begin
    for (int i = 0; i < WIDTH; i++) begin
      hold_cnt[i] = 0;
      hold_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        if (press_pulse[ch])   ev_seen(K_PRESS, ch);
        if (release_pulse[ch]) ev_seen(K_RELEASE, ch);
        if (hold_pulse[ch]) begin
          hold_cnt[ch]++;
          hold_cyc[ch] = cyc;
        end
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int ch);
    data_in[ch] = 1'b0;
    exp_q.push_back({K_PRESS, 1'(ch), 16'(cyc + LAT)});
  endtask

  task automatic release_btn(input int ch);
    data_in[ch] = 1'b1;
    exp_q.push_back({K_RELEASE, 1'(ch), 16'(cyc + LAT)});
  endtask

  task automatic clear_all();
    event_clear = '1;
    step(1);
    event_clear = '0;
    step(1);
  endtask

  int press_cyc;
  int h0;

  initial begin
    // reset
    #2 reset_n = 1'b0;
    #1;
    chk("reset_async_pending", event_pending, 0);
    step(3);
    chk("reset_data_out", data_out, 0);
    chk("reset_pulses", {press_pulse, release_pulse, hold_pulse}, 0);
    chk("reset_pending", event_pending, 0);
    chk("reset_irq", irq, 0);
    chk("reset_state", debug_state, 0);
    reset_n = 1'b1;
    step(3);

    // 1 clean press on ch0
    press(0);
    step(6);
    chk("t1_data_out_before", data_out[0], 0);
    step(1);
    chk("t1_data_out", data_out[0], 1);
    chk("t1_pending_before", event_pending[0], 0);
    step(1);
    chk("t1_pending", event_pending[0], 1);
    chk("t1_irq_before", irq, 0);
    step(1);
    chk("t1_irq", irq, 1);
    release_btn(0);
    step(8);
    chk("t1_released", data_out[0], 0);
    event_clear = 2'b01;
    step(1);
    event_clear = '0;
    chk("t1_pending_cleared", event_pending[0], 0);
    step(1);
    chk("t1_irq_cleared", irq, 0);

    // 2 bounce, then steady press
    for (int i = 0; i < 6; i++) begin
      data_in[0] = i[0];
      step(2);
    end
    press(0);
    step(10);
    chk("t2_data_out", data_out[0], 1);
    release_btn(0);
    step(8);
    clear_all();

    // 3 long press on ch1
    h0 = hold_cnt[1];
    press(1);
    step(LAT);
    press_cyc = cyc;
    step(13);
    chk("t3_hold_once", hold_cnt[1], h0 + 1);
    chk("t3_hold_window", ((hold_cyc[1] - press_cyc) >= 9) && ((hold_cyc[1] - press_cyc) <= 12), 1);
    step(40);
    chk("t3_hold_no_repeat", hold_cnt[1], h0 + 1);
    release_btn(1);
    step(8);
    chk("t3_released", data_out[1], 0);
    chk("t3_hold_after_release", hold_cnt[1], h0 + 1);
    clear_all();

    // 4 short press: input low for 8 clks in total
    h0 = hold_cnt[1];
    press(1);
    step(8);
    release_btn(1);
    step(16);
    chk("t4_no_hold", hold_cnt[1], h0);
    clear_all();

    // 5 clear racing a press pulse
    press(0);
    step(LAT);
    chk("t5_press_level", data_out[0], 1);
    event_clear = 2'b01;
    step(1);
    chk("t5_set_wins", event_pending[0], 1);
    step(1);
    event_clear = '0;
    chk("t5_cleared", event_pending[0], 0);
    chk("t5_irq_lag", irq, 1);
    step(1);
    chk("t5_irq_low", irq, 0);
    release_btn(0);
    step(8);
    clear_all();

    // simultaneous presses on both channels
    press(0);
    press(1);
    step(8);
    chk("sim_data_out", data_out, 2'b11);
    chk("sim_pending", event_pending, 2'b11);
    release_btn(0);
    release_btn(1);
    step(8);
    chk("sim_released", data_out, 2'b00);

    // 6 reset during debounce (pending still set from above)
    chk("t6_irq_set", irq, 1);
    data_in[0] = 1'b0;
    step(6);
    chk("t6_deb_state", debug_state[1:0], 2'(DEB_PRESS));
    reset_n = 1'b0;
    #1;
    chk("t6_async_pending", event_pending, 0);
    chk("t6_async_irq", irq, 0);
    chk("t6_async_state", debug_state, 0);
    step(2);
    reset_n = 1'b1;
    exp_q.push_back({K_PRESS, 1'b0, 16'(cyc + LAT)});
    step(LAT);
    chk("t6_press_after_reset", data_out[0], 1);

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
